vga_sprite_engine: RTL and testbench
====================================

Name: vga_sprite_engine

Overview:
Parametrised VGA timing generator and N-sprite compositor. It is the successor to the fixed 640x480 player/car renderer.
- Generates HS/VS from parameterised timing.
- Composites up to NUM_SPRITES rectangles over a background colour using fixed index priority.
- Double-buffers sprite registers so updates apply only at vblank.
- Reports per-frame sprite-0 collisions to game logic.

Parameters:
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch
- H_PULSE, 96, HS pulse width
- H_BACK, 48, horizontal back porch
- V_DISPLAY, 480, visible lines
- V_FRONT, 10, vertical front porch
- V_PULSE, 2, VS pulse width
- V_BACK, 33, vertical back porch
- SYNC_ACTIVE, 0, polarity of asserted HS/VS (0 = active-low, per VGA 640x480)
- NUM_SPRITES, 5, sprite count; index 0 = player, highest priority
- COORD_W, 10, coordinate/size width
- COLOR_BITS, 3, bits per colour channel

Ports:
- CLK, in, 1, pixel clock
- RST_N, in, 1, synchronous active-low reset
- spr_we, in, 1, write strobe for pending sprite registers
- spr_sel, in, $clog2(NUM_SPRITES), sprite index to write
- spr_en, in, 1, sprite visible
- spr_x, spr_y, in, COORD_W, top-left position
- spr_w, spr_h, in, COORD_W, size in pixels
- spr_rgb, in, 3*COLOR_BITS, sprite colour {R,G,B}
- bg_rgb, in, 3*COLOR_BITS, background colour, sampled per pixel
- VGA_HS, VGA_VS, out, 1, sync outputs
- VGA_R, VGA_G, VGA_B, out, COLOR_BITS each, pixel colour
- frame_start, out, 1, one-cycle pulse at h=0, v=0 (counter domain)
- vblank, out, 1, high while v_count >= V_DISPLAY
- collision, out, NUM_SPRITES, bit i set if sprite i overlapped sprite 0 in the last frame; bit 0 always 0

Behaviour:
Reset values and reset semantics:
- On RST_N=0 at posedge: counters=0, all pending/active sprite regs=0 (disabled), pipeline=0.
- During reset, RGB=0, collision=0, frame_start=0, vblank=0, and HS/VS are deasserted (=~SYNC_ACTIVE).
- Reset mid-frame aborts the frame. The first cycle after release is h=0, v=0, with frame_start=1.

Counters:
- H_TOTAL = sum of the H_ params; V_TOTAL = sum of the V_ params.
- h_count wraps H_TOTAL-1 -> 0. v_count increments on each h wrap and wraps V_TOTAL-1 -> 0.

Sync timing:
- HS is asserted for H_DISPLAY+H_FRONT <= h < H_DISPLAY+H_FRONT+H_PULSE.
- VS is asserted likewise using the V_ parameters.

Pipeline (2 stages; latency 2):
- Stage 1 registers per-sprite hit[i], active_area, and raw sync.
- hit[i] = en_i && x_i <= h < x_i+w_i && y_i <= v < y_i+h_i. Sums are computed at COORD_W+1 bits, so edges past the screen never wrap.
- Stage 2 applies priority:
  - lowest set hit index wins and outputs its colour;
  - with no hit, output bg_rgb (as sampled in stage 1);
  - outside the active area, output 0.
- HS/VS are delayed by the same 2 cycles, so sync, colour and blanking stay aligned.
- w=0 or h=0 never hits.

Double-buffering:
- spr_we writes the pending bank entry spr_sel on the next edge.
- spr_sel >= NUM_SPRITES is ignored.
- At h=0, v=V_DISPLAY (start of vblank), all pending entries are copied to the active bank in one cycle.
- A write in that same cycle lands in pending only and takes effect at the next vblank.
- The active bank never changes during visible lines.

Collision:
- The sticky accumulator is ORed with (hit[i] && hit[0]) for i >= 1, from stage 1 during the active area.
- At the vblank copy cycle, collision <= accumulator and the accumulator clears.
- collision holds for a full frame.

Other outputs:
- frame_start and vblank are registered from counter state, not delayed by the pipeline.

Decomposition:
- Package vga_pkg: the default 640x480 timing constants, the H_TOTAL/V_TOTAL functions, an rgb struct/width function, and the sprite-record field widths.
- Sub-module vga_timing: counters, raw HS/VS, active, frame_start, vblank.
- Compositor, shadow bank and collision logic stay in vga_sprite_engine.

Test Plan:
1. Reset, then run 800*525 cycles with defaults.
   - frame_start pulses exactly once per 420000 cycles.
   - HS is low for 96 cycles, starting 656 cycles after line start (+2 output latency).
   - VS is low for lines 490-491.
2. Sprite 0 at (100,50), 16x16, green 000_111_000, written during vblank; bg=0.
   - Pixel (100,50) is green at output cycle +2.
   - Pixels (99,50) and (116,50) show bg.
3. Sprites 0 and 1 overlap at (200,200); sprite 1 red.
   - The overlap shows sprite 0 colour.
   - collision=5'b00010 after the next vblank, then 0 a frame after sprite 1 moves away.
4. Write sprite 2 x=300 at line 100, mid-frame.
   - The current frame still draws at the old x.
   - The next frame draws at 300.
   - A write exactly at h=0, v=480 appears one frame later.
5. Sprite at x=630, w=20 (edge past H_DISPLAY).
   - Pixels 630-639 are coloured.
   - No wrap artefact at x=0-9.
   - RGB=0 during blanking.
6. RST_N low for 3 cycles at line 300.
   - Outputs go 0 with sync deasserted, and collision clears.
   - Counters restart at 0,0 the first cycle after release.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared constants and helpers for the VGA sprite engine.
// Holds the default 640x480 timing, line/frame total helpers, the packed
// colour layout and the sprite-record field widths.
package vga_pkg;

  // Default 640x480 @ 60 Hz timing.
  localparam int unsigned H_DISPLAY_DEF   = 640;
  localparam int unsigned H_FRONT_DEF     = 16;
  localparam int unsigned H_PULSE_DEF     = 96;
  localparam int unsigned H_BACK_DEF      = 48;
  localparam int unsigned V_DISPLAY_DEF   = 480;
  localparam int unsigned V_FRONT_DEF     = 10;
  localparam int unsigned V_PULSE_DEF     = 2;
  localparam int unsigned V_BACK_DEF      = 33;

  // Sprite-record field widths.
  localparam int unsigned NUM_SPRITES_DEF = 5;
  localparam int unsigned COORD_W_DEF     = 10;
  localparam int unsigned COLOR_BITS_DEF  = 3;

  // Colour is packed {R,G,B}, R in the most significant bits.
  typedef struct packed {
    logic [COLOR_BITS_DEF-1:0] r;
    logic [COLOR_BITS_DEF-1:0] g;
    logic [COLOR_BITS_DEF-1:0] b;
  } rgb_t;

  function automatic int unsigned h_total(input int unsigned disp, input int unsigned front,
                                          input int unsigned pulse, input int unsigned back);
    return disp + front + pulse + back;
  endfunction

  function automatic int unsigned v_total(input int unsigned disp, input int unsigned front,
                                          input int unsigned pulse, input int unsigned back);
    return disp + front + pulse + back;
  endfunction

  function automatic int unsigned rgb_width(input int unsigned color_bits);
    return 3 * color_bits;
  endfunction

  function automatic int unsigned sel_width(input int unsigned num_sprites);
    return (num_sprites > 1) ? $clog2(num_sprites) : 1;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// VGA counter and sync-decode block.
// Ports:
//   i_clk, i_rst_n       pixel clock, synchronous active-low reset
//   o_h_count, o_v_count current pixel position
//   o_hs_raw, o_vs_raw   high while inside the sync pulse (polarity applied later)
//   o_active             high inside the visible area
//   o_frame_start        registered pulse while counters read h=0, v=0
//   o_vblank             registered, high while v_count >= V_DISPLAY
module vga_timing
  import vga_pkg::*;
#(
  parameter int unsigned H_DISPLAY = H_DISPLAY_DEF,
  parameter int unsigned H_FRONT   = H_FRONT_DEF,
  parameter int unsigned H_PULSE   = H_PULSE_DEF,
  parameter int unsigned H_BACK    = H_BACK_DEF,
  parameter int unsigned V_DISPLAY = V_DISPLAY_DEF,
  parameter int unsigned V_FRONT   = V_FRONT_DEF,
  parameter int unsigned V_PULSE   = V_PULSE_DEF,
  parameter int unsigned V_BACK    = V_BACK_DEF,
  parameter int unsigned CNT_W     = COORD_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  output logic [CNT_W-1:0] o_h_count,
  output logic [CNT_W-1:0] o_v_count,
  output logic             o_hs_raw,
  output logic             o_vs_raw,
  output logic             o_active,
  output logic             o_frame_start,
  output logic             o_vblank
);

  localparam int unsigned H_TOTAL = h_total(H_DISPLAY, H_FRONT, H_PULSE, H_BACK);
  localparam int unsigned V_TOTAL = v_total(V_DISPLAY, V_FRONT, V_PULSE, V_BACK);

  logic [CNT_W-1:0] r_h, r_v;
  logic [CNT_W-1:0] w_h_next, w_v_next;
  logic             r_run, r_frame_start, r_vblank;

  // The first edge after reset release holds the counters at 0,0 so that the
  // first released cycle presents h=0, v=0 together with frame_start.
  always_comb begin
    w_h_next = '0;
    w_v_next = '0;
    if (r_run) begin
      if (r_h == CNT_W'(H_TOTAL - 1)) begin
        w_h_next = '0;
        w_v_next = (r_v == CNT_W'(V_TOTAL - 1)) ? '0 : r_v + 1'b1;
      end else begin
        w_h_next = r_h + 1'b1;
        w_v_next = r_v;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_h           <= '0;
      r_v           <= '0;
      r_run         <= 1'b0;
      r_frame_start <= 1'b0;
      r_vblank      <= 1'b0;
    end else begin
      r_h           <= w_h_next;
      r_v           <= w_v_next;
      r_run         <= 1'b1;
      r_frame_start <= (w_h_next == '0) && (w_v_next == '0);
      r_vblank      <= (w_v_next >= CNT_W'(V_DISPLAY));
    end
  end

  assign o_h_count     = r_h;
  assign o_v_count     = r_v;
  assign o_hs_raw      = (r_h >= CNT_W'(H_DISPLAY + H_FRONT)) &&
                         (r_h <  CNT_W'(H_DISPLAY + H_FRONT + H_PULSE));
  assign o_vs_raw      = (r_v >= CNT_W'(V_DISPLAY + V_FRONT)) &&
                         (r_v <  CNT_W'(V_DISPLAY + V_FRONT + V_PULSE));
  // Masked before the counters start so the held 0,0 edge is not drawn twice.
  assign o_active      = r_run && (r_h < CNT_W'(H_DISPLAY)) && (r_v < CNT_W'(V_DISPLAY));
  assign o_frame_start = r_frame_start;
  assign o_vblank      = r_vblank;

endmodule

// File: rtl/vga_sprite_engine.sv
// VGA timing generator with an N-sprite rectangle compositor.
// Ports:
//   CLK, RST_N             pixel clock, synchronous active-low reset
//   spr_we/spr_sel/spr_*   write port into the pending sprite bank
//   bg_rgb                 background colour {R,G,B}, sampled per pixel
//   VGA_HS, VGA_VS         sync outputs, aligned with colour (latency 2)
//   VGA_R, VGA_G, VGA_B    pixel colour
//   frame_start, vblank    counter-domain status (not pipeline delayed)
//   collision              sprites that overlapped sprite 0 in the last frame
// Counters are COORD_W bits wide, so H/V totals must fit in COORD_W bits.
module vga_sprite_engine
  import vga_pkg::*;
#(
  parameter int unsigned H_DISPLAY   = H_DISPLAY_DEF,
  parameter int unsigned H_FRONT     = H_FRONT_DEF,
  parameter int unsigned H_PULSE     = H_PULSE_DEF,
  parameter int unsigned H_BACK      = H_BACK_DEF,
  parameter int unsigned V_DISPLAY   = V_DISPLAY_DEF,
  parameter int unsigned V_FRONT     = V_FRONT_DEF,
  parameter int unsigned V_PULSE     = V_PULSE_DEF,
  parameter int unsigned V_BACK      = V_BACK_DEF,
  parameter bit          SYNC_ACTIVE = 1'b0,
  parameter int unsigned NUM_SPRITES = NUM_SPRITES_DEF,
  parameter int unsigned COORD_W     = COORD_W_DEF,
  parameter int unsigned COLOR_BITS  = COLOR_BITS_DEF
) (
  input  logic                              CLK,
  input  logic                              RST_N,
  input  logic                              spr_we,
  input  logic [sel_width(NUM_SPRITES)-1:0] spr_sel,
  input  logic                              spr_en,
  input  logic [COORD_W-1:0]                spr_x,
  input  logic [COORD_W-1:0]                spr_y,
  input  logic [COORD_W-1:0]                spr_w,
  input  logic [COORD_W-1:0]                spr_h,
  input  logic [rgb_width(COLOR_BITS)-1:0]  spr_rgb,
  input  logic [rgb_width(COLOR_BITS)-1:0]  bg_rgb,
  output logic                              VGA_HS,
  output logic                              VGA_VS,
  output logic [COLOR_BITS-1:0]             VGA_R,
  output logic [COLOR_BITS-1:0]             VGA_G,
  output logic [COLOR_BITS-1:0]             VGA_B,
  output logic                              frame_start,
  output logic                              vblank,
  output logic [NUM_SPRITES-1:0]            collision
);

  localparam int unsigned RGB_W = rgb_width(COLOR_BITS);

  logic [COORD_W-1:0] w_h, w_v;
  logic               w_hs_raw, w_vs_raw, w_active;

  vga_timing #(
    .H_DISPLAY (H_DISPLAY),
    .H_FRONT   (H_FRONT),
    .H_PULSE   (H_PULSE),
    .H_BACK    (H_BACK),
    .V_DISPLAY (V_DISPLAY),
    .V_FRONT   (V_FRONT),
    .V_PULSE   (V_PULSE),
    .V_BACK    (V_BACK),
    .CNT_W     (COORD_W)
  ) u_timing (
    .i_clk         (CLK),
    .i_rst_n       (RST_N),
    .o_h_count     (w_h),
    .o_v_count     (w_v),
    .o_hs_raw      (w_hs_raw),
    .o_vs_raw      (w_vs_raw),
    .o_active      (w_active),
    .o_frame_start (frame_start),
    .o_vblank      (vblank)
  );

  // Pending (CPU-written) and active (displayed) sprite banks.
  logic               r_pend_en  [NUM_SPRITES];
  logic [COORD_W-1:0] r_pend_x   [NUM_SPRITES];
  logic [COORD_W-1:0] r_pend_y   [NUM_SPRITES];
  logic [COORD_W-1:0] r_pend_w   [NUM_SPRITES];
  logic [COORD_W-1:0] r_pend_h   [NUM_SPRITES];
  logic [RGB_W-1:0]   r_pend_rgb [NUM_SPRITES];
  logic               r_act_en   [NUM_SPRITES];
  logic [COORD_W-1:0] r_act_x    [NUM_SPRITES];
  logic [COORD_W-1:0] r_act_y    [NUM_SPRITES];
  logic [COORD_W-1:0] r_act_w    [NUM_SPRITES];
  logic [COORD_W-1:0] r_act_h    [NUM_SPRITES];
  logic [RGB_W-1:0]   r_act_rgb  [NUM_SPRITES];

  logic w_copy;
  assign w_copy = (w_h == '0) && (w_v == COORD_W'(V_DISPLAY));

  // A write in the copy cycle lands in pending only; active takes the old value.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        r_pend_en[i]  <= 1'b0;
        r_pend_x[i]   <= '0;
        r_pend_y[i]   <= '0;
        r_pend_w[i]   <= '0;
        r_pend_h[i]   <= '0;
        r_pend_rgb[i] <= '0;
        r_act_en[i]   <= 1'b0;
        r_act_x[i]    <= '0;
        r_act_y[i]    <= '0;
        r_act_w[i]    <= '0;
        r_act_h[i]    <= '0;
        r_act_rgb[i]  <= '0;
      end
    end else begin
      if (spr_we && (32'(spr_sel) < NUM_SPRITES)) begin
        r_pend_en[spr_sel]  <= spr_en;
        r_pend_x[spr_sel]   <= spr_x;
        r_pend_y[spr_sel]   <= spr_y;
        r_pend_w[spr_sel]   <= spr_w;
        r_pend_h[spr_sel]   <= spr_h;
        r_pend_rgb[spr_sel] <= spr_rgb;
      end
      if (w_copy) begin
        for (int i = 0; i < NUM_SPRITES; i++) begin
          r_act_en[i]  <= r_pend_en[i];
          r_act_x[i]   <= r_pend_x[i];
          r_act_y[i]   <= r_pend_y[i];
          r_act_w[i]   <= r_pend_w[i];
          r_act_h[i]   <= r_pend_h[i];
          r_act_rgb[i] <= r_pend_rgb[i];
        end
      end
    end
  end

  // Far edges are summed one bit wider so sprites hanging off-screen never wrap.
  logic [NUM_SPRITES-1:0] w_hit;
  always_comb begin
    w_hit = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      w_hit[i] = r_act_en[i] &&
                 (w_h >= r_act_x[i]) &&
                 ({1'b0, w_h} < ({1'b0, r_act_x[i]} + {1'b0, r_act_w[i]})) &&
                 (w_v >= r_act_y[i]) &&
                 ({1'b0, w_v} < ({1'b0, r_act_y[i]} + {1'b0, r_act_h[i]}));
    end
  end

  // Stage 1: hits, blanking, raw sync and background.
  logic [NUM_SPRITES-1:0] r_s1_hit;
  logic                   r_s1_active, r_s1_hs, r_s1_vs;
  logic [RGB_W-1:0]       r_s1_bg;
  // Stage 2: final colour and sync.
  logic [RGB_W-1:0]       r_s2_rgb;
  logic                   r_s2_hs, r_s2_vs;

  // Walk from the highest index down so the lowest hit index wins.
  logic [RGB_W-1:0] w_pix;
  always_comb begin
    w_pix = r_s1_bg;
    for (int i = int'(NUM_SPRITES) - 1; i >= 0; i--) begin
      if (r_s1_hit[i]) w_pix = r_act_rgb[i];
    end
    if (!r_s1_active) w_pix = '0;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_s1_hit    <= '0;
      r_s1_active <= 1'b0;
      r_s1_hs     <= 1'b0;
      r_s1_vs     <= 1'b0;
      r_s1_bg     <= '0;
      r_s2_rgb    <= '0;
      r_s2_hs     <= 1'b0;
      r_s2_vs     <= 1'b0;
    end else begin
      r_s1_hit    <= w_hit;
      r_s1_active <= w_active;
      r_s1_hs     <= w_hs_raw;
      r_s1_vs     <= w_vs_raw;
      r_s1_bg     <= bg_rgb;
      r_s2_rgb    <= w_pix;
      r_s2_hs     <= r_s1_hs;
      r_s2_vs     <= r_s1_vs;
    end
  end

  // Sticky overlap with sprite 0; bit 0 is masked off.
  logic [NUM_SPRITES-1:0] r_coll_acc, r_collision, w_overlap;
  assign w_overlap = (r_s1_active && r_s1_hit[0]) ?
                     (r_s1_hit & ~NUM_SPRITES'(1)) : '0;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_coll_acc  <= '0;
      r_collision <= '0;
    end else if (w_copy) begin
      r_collision <= r_coll_acc;
      r_coll_acc  <= '0;
    end else begin
      r_coll_acc  <= r_coll_acc | w_overlap;
    end
  end

  assign collision = r_collision;
  assign VGA_HS    = r_s2_hs ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  assign VGA_VS    = r_s2_vs ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  assign VGA_R     = r_s2_rgb[RGB_W-1 -: COLOR_BITS];
  assign VGA_G     = r_s2_rgb[2*COLOR_BITS-1 -: COLOR_BITS];
  assign VGA_B     = r_s2_rgb[COLOR_BITS-1:0];

endmodule

// File: tb/tb_vga_sprite_engine.sv
// Directed bench for vga_sprite_engine, built with a reduced 80x38 timing so
// whole frames stay short. Coordinates are scaled versions of the 640x480 cases.
module tb_vga_sprite_engine;

  localparam int unsigned HD = 64, HF = 4, HP = 8, HB = 4, HT = 80;
  localparam int unsigned VD = 32, VF = 2, VP = 2, VB = 2, VT = 38;

  localparam logic [8:0] BLACK = 9'b000_000_000;
  localparam logic [8:0] GREEN = 9'b000_111_000;
  localparam logic [8:0] RED   = 9'b111_000_000;
  localparam logic [8:0] BLUE  = 9'b000_000_111;
  localparam logic [8:0] WHITE = 9'b111_111_111;
  localparam logic [8:0] GREY  = 9'b001_001_001;
  localparam logic [8:0] MAUVE = 9'b101_101_101;
  localparam logic [8:0] TEAL  = 9'b001_010_011;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       spr_we = 1'b0;
  logic [2:0] spr_sel = '0;
  logic       spr_en = 1'b0;
  logic [9:0] spr_x = '0, spr_y = '0, spr_w = '0, spr_h = '0;
  logic [8:0] spr_rgb = '0, bg_rgb = '0;
  logic       VGA_HS, VGA_VS;
  logic [2:0] VGA_R, VGA_G, VGA_B;
  logic       frame_start, vblank;
  logic [4:0] collision;

  vga_sprite_engine #(
    .H_DISPLAY   (HD),
    .H_FRONT     (HF),
    .H_PULSE     (HP),
    .H_BACK      (HB),
    .V_DISPLAY   (VD),
    .V_FRONT     (VF),
    .V_PULSE     (VP),
    .V_BACK      (VB),
    .SYNC_ACTIVE (1'b0),
    .NUM_SPRITES (5),
    .COORD_W     (10),
    .COLOR_BITS  (3)
  ) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .spr_we      (spr_we),
    .spr_sel     (spr_sel),
    .spr_en      (spr_en),
    .spr_x       (spr_x),
    .spr_y       (spr_y),
    .spr_w       (spr_w),
    .spr_h       (spr_h),
    .spr_rgb     (spr_rgb),
    .bg_rgb      (bg_rgb),
    .VGA_HS      (VGA_HS),
    .VGA_VS      (VGA_VS),
    .VGA_R       (VGA_R),
    .VGA_G       (VGA_G),
    .VGA_B       (VGA_B),
    .frame_start (frame_start),
    .vblank      (vblank),
    .collision   (collision)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;
  int tb_h = 0, tb_v = 0;
  bit tb_run = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge CLK);
    #1;
    if (tb_run) begin
      if (tb_h == HT - 1) begin
        tb_h = 0;
        tb_v = (tb_v == VT - 1) ? 0 : tb_v + 1;
      end else begin
        tb_h++;
      end
    end
  endtask

  // Advance to the next cycle whose counters read (h, v).
  task automatic goto(input int h, input int v);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!(tb_h == h && tb_v == v) && n <= HT * VT);
    if (!(tb_h == h && tb_v == v)) chk("goto_timeout", 32'(n), 32'(HT * VT));
  endtask

  // Pixel (x, y) reaches the outputs two cycles after the counters show it.
  task automatic chk_pix(input string tag, input int x, input int y, input logic [8:0] exp);
    goto(x + 2, y);
    chk(tag, 32'({VGA_R, VGA_G, VGA_B}), 32'(exp));
  endtask

  task automatic wr(input logic [2:0] sel, input logic en, input logic [9:0] x,
                    input logic [9:0] y, input logic [9:0] w, input logic [9:0] h,
                    input logic [8:0] rgb);
    spr_sel = sel;
    spr_en  = en;
    spr_x   = x;
    spr_y   = y;
    spr_w   = w;
    spr_h   = h;
    spr_rgb = rgb;
    spr_we  = 1'b1;
    step();
    spr_we  = 1'b0;
  endtask

  // Pass the edge that copies pending into active.
  task automatic vblank_copy();
    goto(0, VD);
    step();
  endtask

  initial begin
    int fs_cnt, fs_err, vb_err, hs_err, vs_err, rgb_err, hs_low, vs_low;
    int ph, pv, k;
    logic exp_hs, exp_vs;
    logic [8:0] exp_rgb;

    // ---- Reset ----
    bg_rgb = TEAL;
    step();
    chk("rst_rgb", 32'({VGA_R, VGA_G, VGA_B}), 32'(0));
    chk("rst_hs", 32'(VGA_HS), 32'(1));
    chk("rst_vs", 32'(VGA_VS), 32'(1));
    chk("rst_fs", 32'(frame_start), 32'(0));
    chk("rst_vblank", 32'(vblank), 32'(0));
    chk("rst_coll", 32'(collision), 32'(0));
    step();
    step();
    RST_N = 1'b1;
    step();
    tb_h = 0;
    tb_v = 0;
    tb_run = 1'b1;
    chk("rel_fs", 32'(frame_start), 32'(1));
    chk("rel_vblank", 32'(vblank), 32'(0));

    // ---- 1: one full frame of timing, background only ----
    fs_cnt = 0; fs_err = 0; vb_err = 0; hs_err = 0; vs_err = 0; rgb_err = 0;
    hs_low = 0; vs_low = 0;
    for (int n = 0; n < HT * VT; n++) begin
      step();
      ph = (tb_h >= 2) ? tb_h - 2 : tb_h + HT - 2;
      pv = (tb_h >= 2) ? tb_v : ((tb_v == 0) ? VT - 1 : tb_v - 1);
      exp_hs  = !(ph >= HD + HF && ph < HD + HF + HP);
      exp_vs  = !(pv >= VD + VF && pv < VD + VF + VP);
      exp_rgb = (ph < HD && pv < VD) ? TEAL : BLACK;
      if (frame_start) fs_cnt++;
      if (frame_start !== (tb_h == 0 && tb_v == 0)) fs_err++;
      if (vblank !== (tb_v >= VD)) vb_err++;
      if (VGA_HS !== exp_hs) hs_err++;
      if (VGA_VS !== exp_vs) vs_err++;
      if ({VGA_R, VGA_G, VGA_B} !== exp_rgb) rgb_err++;
      if (VGA_HS === 1'b0) hs_low++;
      if (VGA_VS === 1'b0) vs_low++;
    end
    chk("t1_fs_per_frame", 32'(fs_cnt), 32'(1));
    chk("t1_fs_position", 32'(fs_err), 32'(0));
    chk("t1_vblank", 32'(vb_err), 32'(0));
    chk("t1_hs_shape", 32'(hs_err), 32'(0));
    chk("t1_vs_shape", 32'(vs_err), 32'(0));
    chk("t1_hs_low_cycles", 32'(hs_low), 32'(HP * VT));
    chk("t1_vs_low_cycles", 32'(vs_low), 32'(VP * HT));
    chk("t1_rgb_bg_blank", 32'(rgb_err), 32'(0));
    goto(HD + HF + 1, 1);
    chk("t1_hs_before", 32'(VGA_HS), 32'(1));
    step();
    chk("t1_hs_first", 32'(VGA_HS), 32'(0));
    goto(HD + HF + HP + 1, 1);
    chk("t1_hs_last", 32'(VGA_HS), 32'(0));
    step();
    chk("t1_hs_after", 32'(VGA_HS), 32'(1));

    // ---- 2: single sprite edges ----
    bg_rgb = BLACK;
    wr(3'd0, 1'b1, 10'd10, 10'd5, 10'd8, 10'd8, GREEN);
    vblank_copy();
    chk_pix("t2_left_bg", 9, 5, BLACK);
    chk_pix("t2_first", 10, 5, GREEN);
    chk_pix("t2_last", 17, 5, GREEN);
    chk_pix("t2_right_bg", 18, 5, BLACK);
    chk_pix("t2_bottom", 10, 12, GREEN);
    chk_pix("t2_below", 10, 13, BLACK);

    // ---- 3: priority and collision ----
    wr(3'd1, 1'b1, 10'd14, 10'd8, 10'd8, 10'd8, RED);
    vblank_copy();
    chk("t3_coll_none", 32'(collision), 32'(0));
    chk_pix("t3_s0_only", 11, 6, GREEN);
    chk_pix("t3_overlap", 15, 9, GREEN);
    chk_pix("t3_s1_only", 19, 9, RED);
    wr(3'd1, 1'b1, 10'd40, 10'd20, 10'd8, 10'd8, RED);
    vblank_copy();
    chk("t3_coll_set", 32'(collision), 32'(5'b00010));
    chk_pix("t3_s1_moved", 40, 20, RED);
    chk("t3_coll_hold", 32'(collision), 32'(5'b00010));
    vblank_copy();
    chk("t3_coll_clear", 32'(collision), 32'(0));

    // ---- 4: double buffering ----
    wr(3'd2, 1'b1, 10'd20, 10'd25, 10'd4, 10'd4, BLUE);
    vblank_copy();
    goto(0, 10);
    wr(3'd2, 1'b1, 10'd30, 10'd25, 10'd4, 10'd4, BLUE);
    chk_pix("t4_old_x", 20, 25, BLUE);
    chk_pix("t4_new_pending", 30, 25, BLACK);
    vblank_copy();
    chk_pix("t4_old_gone", 20, 25, BLACK);
    chk_pix("t4_new_x", 30, 25, BLUE);
    goto(0, VD);
    wr(3'd2, 1'b1, 10'd50, 10'd25, 10'd4, 10'd4, BLUE);
    chk_pix("t4_edge_still_old", 30, 25, BLUE);
    chk_pix("t4_edge_not_yet", 50, 25, BLACK);
    vblank_copy();
    chk_pix("t4_edge_old_gone", 30, 25, BLACK);
    chk_pix("t4_edge_applied", 50, 25, BLUE);

    // ---- 5: right-edge clipping, blanking, priority 0 over 4 ----
    bg_rgb = GREY;
    wr(3'd3, 1'b1, 10'd60, 10'd28, 10'd8, 10'd4, WHITE);
    wr(3'd4, 1'b1, 10'd12, 10'd6, 10'd2, 10'd2, MAUVE);
    vblank_copy();
    chk_pix("t5_bg", 9, 5, GREY);
    chk_pix("t5_s0_over_s4", 12, 6, GREEN);
    chk_pix("t5_edge_first", 60, 28, WHITE);
    chk_pix("t5_edge_last", 63, 28, WHITE);
    chk_pix("t5_hblank_hit", 64, 28, BLACK);
    chk_pix("t5_no_wrap", 0, 29, GREY);
    chk_pix("t5_hblank", 70, 29, BLACK);
    chk_pix("t5_vblank", 10, VD + 1, BLACK);
    chk("t5_coll_s4", 32'(collision), 32'(5'b10000));

    // ---- 6: mid-frame reset ----
    goto(0, 30);
    chk("t6_coll_pre", 32'(collision), 32'(5'b10000));
    RST_N  = 1'b0;
    tb_run = 1'b0;
    step();
    chk("t6_rst_rgb", 32'({VGA_R, VGA_G, VGA_B}), 32'(0));
    chk("t6_rst_hs", 32'(VGA_HS), 32'(1));
    chk("t6_rst_vs", 32'(VGA_VS), 32'(1));
    chk("t6_rst_coll", 32'(collision), 32'(0));
    chk("t6_rst_fs", 32'(frame_start), 32'(0));
    step();
    step();
    RST_N = 1'b1;
    step();
    tb_h = 0;
    tb_v = 0;
    tb_run = 1'b1;
    chk("t6_rel_fs", 32'(frame_start), 32'(1));
    chk("t6_rel_vblank", 32'(vblank), 32'(0));
    k = 0;
    while (vblank !== 1'b1 && k < 2 * HT * VT) begin
      step();
      k++;
    end
    chk("t6_restart_to_vblank", 32'(k), 32'(VD * HT));
    chk_pix("t6_sprites_cleared", 12, 6, GREY);
    chk("t6_coll_after", 32'(collision), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
